// File: rtl/sys_defs_pkg.sv
// Shared fetch-side definitions: datapath width, default queue depth and the
// packet carried from fetch to decode.
package sys_defs;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned DEF_FQ_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] PC;
    logic [31:0]     inst;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } IF_PACKET;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage boundary bundle: BTB/I-cache lookup, back-end redirect and
// the fetch-queue handshake toward decode.
interface if_stage_if;
  import sys_defs::*;

  logic [XLEN-1:0] if_PC;
  logic            btb_taken;
  logic [XLEN-1:0] btb_target_PC;
  logic            icache_valid;
  logic [31:0]     icache_inst;
  logic            redirect_en;
  logic [XLEN-1:0] redirect_PC;
  logic            fq_valid;
  logic [XLEN-1:0] fq_PC;
  logic [31:0]     fq_inst;
  logic            fq_pred_taken;
  logic [XLEN-1:0] fq_pred_target;
  logic            id_ready;

  modport master (
    output if_PC, fq_valid, fq_PC, fq_inst, fq_pred_taken, fq_pred_target,
    input  btb_taken, btb_target_PC, icache_valid, icache_inst, redirect_en, redirect_PC,
           id_ready
  );

  modport slave (
    input  if_PC, fq_valid, fq_PC, fq_inst, fq_pred_taken, fq_pred_target,
    output btb_taken, btb_target_PC, icache_valid, icache_inst, redirect_en, redirect_PC,
           id_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch packets. The head is read straight from registered
// storage, so a push becomes visible no earlier than the following cycle.
module fetch_queue import sys_defs::*; #(
  parameter int unsigned DEPTH = DEF_FQ_DEPTH
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  logic     flush,
  input  IF_PACKET din,
  output IF_PACKET head,
  output logic     valid,
  output logic     full
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  IF_PACKET        mem_q [DEPTH];
  logic [PtrW-1:0] head_q, tail_q;
  logic [PtrW:0]   count_q;
  logic            push_ok, pop_ok;

  assign valid   = (count_q != '0);
  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign head    = mem_q[head_q];
  assign pop_ok  = pop && valid;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[tail_q] <= din;
        tail_q        <= tail_q + PtrW'(1);
      end
      if (pop_ok) begin
        head_q <= head_q + PtrW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, picks redirect / BTB / PC+4 as
// the next PC and enqueues fetched instructions for decode.
module if_stage import sys_defs::*; #(
  parameter int unsigned     FQ_DEPTH = DEF_FQ_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic             clock,
  input logic             reset,
  if_stage_if.master      fe
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] seq_pc, pred_pc;
  logic            pop, push, flush;
  logic            fq_full, fq_head_valid;
  IF_PACKET        enq_pkt, head_pkt;

  assign seq_pc  = pc_q + XLEN'(4);
  assign pred_pc = fe.btb_taken ? fe.btb_target_PC : seq_pc;

  assign flush = fe.redirect_en;
  assign pop   = fq_head_valid && fe.id_ready;
  assign push  = fe.icache_valid && !fe.redirect_en && (!fq_full || pop);

  assign enq_pkt = '{
    PC:          pc_q,
    inst:        fe.icache_inst,
    pred_taken:  fe.btb_taken,
    pred_target: pred_pc
  };

  // Without a push the same address is re-presented to the BTB and I-cache.
  always_comb begin
    pc_d = pc_q;
    if (fe.redirect_en) begin
      pc_d = {fe.redirect_PC[XLEN-1:2], 2'b00};
    end else if (push) begin
      pc_d = pred_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (enq_pkt),
    .head  (head_pkt),
    .valid (fq_head_valid),
    .full  (fq_full)
  );

  assign fe.if_PC          = pc_q;
  assign fe.fq_valid       = fq_head_valid;
  assign fe.fq_PC          = head_pkt.PC;
  assign fe.fq_inst        = head_pkt.inst;
  assign fe.fq_pred_taken  = head_pkt.pred_taken;
  assign fe.fq_pred_target = head_pkt.pred_target;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, BTB hit, stall on full queue,
// redirect flush, reset priority, I-cache miss and PC wrap-around.
module tb_if_stage;
  import sys_defs::*;

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic            btb_en;
  logic [XLEN-1:0] btb_pc, btb_tgt;

  if_stage_if bus ();

  if_stage #(
    .FQ_DEPTH (4),
    .RESET_PC ('0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .fe    (bus)
  );

  always #5 clock = ~clock;

  // BTB and I-cache respond combinationally to the presented PC.
  assign bus.btb_taken     = btb_en && (bus.if_PC == btb_pc);
  assign bus.btb_target_PC = btb_tgt;
  assign bus.icache_inst   = 32'hA000_0000 ^ bus.if_PC;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    btb_en           = 1'b0;
    btb_pc           = '0;
    btb_tgt          = '0;
    bus.icache_valid = 1'b1;
    bus.redirect_en  = 1'b0;
    bus.redirect_PC  = '0;
    bus.id_ready     = 1'b1;

    // Sequential fetch
    do_reset();
    check("rst_if_pc", bus.if_PC, 32'h0);
    check("rst_fq_valid", 32'(bus.fq_valid), 32'h0);
    check("rst_fq_pc", bus.fq_PC, 32'h0);
    check("rst_fq_inst", bus.fq_inst, 32'h0);
    check("rst_fq_taken", 32'(bus.fq_pred_taken), 32'h0);
    check("rst_fq_target", bus.fq_pred_target, 32'h0);
    step();
    check("seq_if_pc_4", bus.if_PC, 32'h4);
    check("seq_fq_valid", 32'(bus.fq_valid), 32'h1);
    check("seq_fq_pc_0", bus.fq_PC, 32'h0);
    check("seq_fq_inst_0", bus.fq_inst, 32'hA000_0000);
    check("seq_fq_target_0", bus.fq_pred_target, 32'h4);
    step();
    check("seq_if_pc_8", bus.if_PC, 32'h8);
    check("seq_fq_pc_4", bus.fq_PC, 32'h4);
    step();
    check("seq_if_pc_c", bus.if_PC, 32'hC);
    check("seq_fq_pc_8", bus.fq_PC, 32'h8);
    check("seq_fq_taken", 32'(bus.fq_pred_taken), 32'h0);

    // BTB hit at 0x8 -> 0x40
    btb_en  = 1'b1;
    btb_pc  = 32'h8;
    btb_tgt = 32'h40;
    do_reset();
    step();
    step();
    check("btb_pre_if_pc", bus.if_PC, 32'h8);
    step();
    check("btb_if_pc", bus.if_PC, 32'h40);
    check("btb_fq_pc", bus.fq_PC, 32'h8);
    check("btb_fq_taken", 32'(bus.fq_pred_taken), 32'h1);
    check("btb_fq_target", bus.fq_pred_target, 32'h40);
    step();
    check("btb_after_if_pc", bus.if_PC, 32'h44);
    check("btb_after_fq_pc", bus.fq_PC, 32'h40);
    check("btb_after_taken", 32'(bus.fq_pred_taken), 32'h0);
    btb_en = 1'b0;

    // Decode stalled: four pushes fill the queue, then fetch holds
    bus.id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    check("full_if_pc", bus.if_PC, 32'h10);
    check("full_fq_pc", bus.fq_PC, 32'h0);
    step();
    step();
    check("stall_if_pc", bus.if_PC, 32'h10);
    check("stall_fq_valid", 32'(bus.fq_valid), 32'h1);
    bus.id_ready = 1'b1;
    step();
    check("drain1_if_pc", bus.if_PC, 32'h14);
    check("drain1_fq_pc", bus.fq_PC, 32'h4);
    step();
    check("drain2_if_pc", bus.if_PC, 32'h18);
    check("drain2_fq_pc", bus.fq_PC, 32'h8);
    bus.id_ready = 1'b0;
    step();
    check("still_full_if_pc", bus.if_PC, 32'h18);
    check("still_full_fq_pc", bus.fq_PC, 32'h8);

    // Redirect with three queued entries
    do_reset();
    for (int i = 0; i < 3; i++) step();
    check("pre_redir_if_pc", bus.if_PC, 32'hC);
    bus.id_ready    = 1'b1;
    bus.redirect_en = 1'b1;
    bus.redirect_PC = 32'h103;
    step();
    bus.redirect_en = 1'b0;
    check("redir_fq_valid", 32'(bus.fq_valid), 32'h0);
    check("redir_if_pc", bus.if_PC, 32'h100);
    step();
    check("redir_fq_pc", bus.fq_PC, 32'h100);
    check("redir_fq_valid2", 32'(bus.fq_valid), 32'h1);
    check("redir_if_pc2", bus.if_PC, 32'h104);

    // Reset wins over redirect with a full queue
    bus.id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    reset           = 1'b1;
    bus.redirect_en = 1'b1;
    bus.redirect_PC = 32'h200;
    step();
    reset           = 1'b0;
    bus.redirect_en = 1'b0;
    check("rst_redir_if_pc", bus.if_PC, 32'h0);
    check("rst_redir_fq_valid", 32'(bus.fq_valid), 32'h0);

    // I-cache miss at 0x20
    bus.id_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) step();
    check("miss_pre_if_pc", bus.if_PC, 32'h20);
    check("miss_pre_fq_pc", bus.fq_PC, 32'h1C);
    bus.icache_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("miss_if_pc", bus.if_PC, 32'h20);
      check("miss_fq_valid", 32'(bus.fq_valid), 32'h0);
    end
    bus.icache_valid = 1'b1;
    step();
    check("resume_if_pc", bus.if_PC, 32'h24);
    check("resume_fq_pc", bus.fq_PC, 32'h20);
    check("resume_fq_inst", bus.fq_inst, 32'hA000_0020);
    step();
    check("resume_nodup_fq_pc", bus.fq_PC, 32'h24);

    // PC+4 wraps at the top of the address space
    bus.redirect_en = 1'b1;
    bus.redirect_PC = 32'hFFFF_FFFE;
    step();
    bus.redirect_en = 1'b0;
    check("wrap_redir_if_pc", bus.if_PC, 32'hFFFF_FFFC);
    step();
    check("wrap_if_pc", bus.if_PC, 32'h0);
    check("wrap_fq_pc", bus.fq_PC, 32'hFFFF_FFFC);
    check("wrap_fq_target", bus.fq_pred_target, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
